// File: rtl/spi_slave_core.sv
// SPI mode-0 slave endpoint, MSB first, fully oversampled in the clk domain.
// Optional truncated-frame / stray-clock detection on frame_err: define SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    // state     | meaning
    // ST_IDLE   | deselected, miso held 0, waiting for cs_s low
    // ST_ACTIVE | selected, shifting on synchronized sclk edges
    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    sclk_dly_q, sclk_dly_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    word_done_q, word_done_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
    logic                    tx_full_q, tx_full_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                    frame_err_q, frame_err_d;
`endif

    logic                    sclk_s, cs_s, mosi_s;
    logic                    rise, fall;
    logic                    consume;
    logic [DATA_WIDTH-1:0]   tx_word;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_dly_q;
    assign fall    = ~sclk_s & sclk_dly_q;
    assign tx_word = tx_full_q ? tx_buf_q : '0;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_dly_d  = sclk_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = word_done_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        consume     = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!cs_s) begin
                    state_d     = ST_ACTIVE;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    rx_shift_d  = '0;
                    tx_shift_d  = tx_word;
                    consume     = 1'b1;
                end
`ifdef SPI_SLAVE_FRAME_ERR_EN
                if (cs_s && rise) frame_err_d = 1'b1;
`endif
            end
            ST_ACTIVE: begin
                // Deselect has priority over a coincident sclk edge.
                if (cs_s) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    rx_shift_d  = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    if (bit_cnt_q != '0) frame_err_d = 1'b1;
`endif
                end else begin
                    if (rise) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                            rx_valid_d  = 1'b1;
                            bit_cnt_d   = '0;
                            word_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (fall) begin
                        if (word_done_q) begin
                            tx_shift_d  = tx_word;
                            consume     = 1'b1;
                            word_done_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load into an empty buffer survives a same-cycle consume (which saw zeros).
        tx_buf_d  = tx_buf_q;
        tx_full_d = tx_full_q;
        if (tx_load && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end else if (consume) begin
            tx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign miso     = (state_q == ST_ACTIVE) & tx_shift_q[DATA_WIDTH-1];
    assign busy     = (state_q == ST_ACTIVE);
    assign tx_ready = ~tx_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a mode-0 SPI master model, a TX feeder, and a monitor that logs rx words.
// Honours SPI_SLAVE_FRAME_ERR_EN for the expected frame_err count.
module tb_spi_slave_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = '0;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;

    spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] rx_log[$];
    int         fe_total = 0;
    int         rv_run = 0;
    int         max_rv_run = 0;

    logic [7:0] mosi_words[$];
    logic [7:0] miso_words[$];
    logic [7:0] exp_miso[$];
    logic [7:0] feed_words[$];
    int         frame_rx_base;
    int         frame_fe_base;

    typedef struct {
        bit         has_tx;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         half;
    } vec_t;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log.push_back(rx_data);
            rv_run++;
        end else begin
            rv_run = 0;
        end
        if (rv_run > max_rv_run) max_rv_run = rv_run;
        if (frame_err) fe_total++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic feed(input logic [7:0] w);
        int i;
        for (i = 0; i < 1000 && !tx_ready; i++) @(negedge clk);
        if (!tx_ready) check("feed_timeout", 0, 1);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Mode-0 master: data changes while sclk is low, MISO sampled just before each rising edge.
    task automatic run_frame(input int half, input int stop_after);
        int         rises;
        bit         stop;
        logic [7:0] cap;
        rises = 0;
        stop = 0;
        miso_words.delete();
        @(negedge clk);
        frame_rx_base = rx_log.size();
        frame_fe_base = fe_total;
        cs_n = 1'b0;
        foreach (mosi_words[k]) begin
            if (!stop) begin
                cap = '0;
                for (int b = 7; b >= 0; b--) begin
                    if (!stop) begin
                        mosi = mosi_words[k][b];
                        repeat (half) @(negedge clk);
                        cap = {cap[6:0], miso};
                        sclk = 1'b1;
                        rises++;
                        repeat (half) @(negedge clk);
                        sclk = 1'b0;
                        if (rises == stop_after) stop = 1;
                    end
                end
                if (!stop) miso_words.push_back(cap);
            end
        end
        mosi = 1'b0;
        repeat (half) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * half + 8) @(negedge clk);
    endtask

    task automatic verify_frame(input string tag);
        check({tag, "_rx_count"}, rx_log.size() - frame_rx_base, mosi_words.size());
        foreach (mosi_words[k]) begin
            if (k < miso_words.size()) check({tag, "_miso_word"}, miso_words[k], exp_miso[k]);
            else check({tag, "_miso_missing"}, 0, 1);
            if (frame_rx_base + k < rx_log.size())
                check({tag, "_rx_word"}, rx_log[frame_rx_base + k], mosi_words[k]);
        end
        check({tag, "_rx_data_hold"}, rx_data, mosi_words[mosi_words.size() - 1]);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_err"}, fe_total - frame_fe_base, 0);
    endtask

    initial begin
        vec_t       vecs[5];
        logic [7:0] saved_rx;
        int         exp_fe;
        int         m, l;

        vecs[0] = '{1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 28};
        vecs[1] = '{0, 8'h00, 8'hFF, 8'h00, 8'hFF, 5};
        vecs[2] = '{1, 8'hFF, 8'h00, 8'hFF, 8'h00, 4};
        vecs[3] = '{1, 8'h81, 8'h7E, 8'h81, 8'h7E, 6};
        vecs[4] = '{1, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 4};

        repeat (4) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].has_tx) feed(vecs[i].tx);
            mosi_words = '{vecs[i].mosi};
            exp_miso = '{vecs[i].exp_miso};
            run_frame(vecs[i].half, -1);
            verify_frame($sformatf("vec%0d", i));
            check($sformatf("vec%0d_rx_expected", i), rx_data, vecs[i].exp_rx);
        end

        // Back-to-back words in one frame, second TX word loaded after the first consume.
        feed(8'hC3);
        mosi_words = '{8'h12, 8'h34};
        exp_miso = '{8'hC3, 8'h5A};
        fork
            run_frame(5, -1);
            feed(8'h5A);
        join
        verify_frame("b2b");

        // Second load while the buffer is full is dropped.
        feed(8'h11);
        check("hs_ready_low", tx_ready, 0);
        tx_data = 8'h22;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        check("hs_ready_still_low", tx_ready, 0);
        mosi_words = '{8'hE7};
        exp_miso = '{8'h11};
        run_frame(4, -1);
        verify_frame("hs_first");
        mosi_words = '{8'h18};
        exp_miso = '{8'h00};
        run_frame(4, -1);
        verify_frame("hs_dropped");

        // Frame truncated after 5 rises.
        saved_rx = rx_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        exp_fe = 1;
`else
        exp_fe = 0;
`endif
        feed(8'hF0);
        mosi_words = '{8'hAB};
        run_frame(4, 5);
        check("abort_rx_count", rx_log.size() - frame_rx_base, 0);
        check("abort_rx_hold", rx_data, saved_rx);
        check("abort_busy", busy, 0);
        check("abort_frame_err", fe_total - frame_fe_base, exp_fe);

        // Reset in the middle of a frame.
        feed(8'h77);
        @(negedge clk);
        cs_n = 1'b0;
        mosi = 1'b1;
        for (int b = 0; b < 3; b++) begin
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        check("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_miso", miso, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        feed(8'h96);
        mosi_words = '{8'h69};
        exp_miso = '{8'h96};
        run_frame(6, -1);
        verify_frame("post_rst");

        // Randomized frames: word k of a frame carries the k-th fed word, zeros once the feed runs dry.
        for (int f = 0; f < 12; f++) begin
            m = $urandom_range(1, 3);
            l = $urandom_range(0, m + 1);
            mosi_words.delete();
            exp_miso.delete();
            feed_words.delete();
            for (int k = 0; k < l; k++) feed_words.push_back(8'($urandom));
            for (int k = 0; k < m; k++) begin
                mosi_words.push_back(8'($urandom));
                exp_miso.push_back(k < l ? feed_words[k] : 8'h00);
            end
            if (l > 0) feed(feed_words[0]);
            fork
                run_frame($urandom_range(4, 7), -1);
                begin
                    for (int k = 1; k < l; k++) feed(feed_words[k]);
                end
            join
            verify_frame($sformatf("rand%0d", f));
        end

        check("rx_valid_width", max_rv_run, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
SPI slave endpoint, mode 0 (CPOL=0, CPHA=0), MSB first. It receives the SCLK/CS_N/MOSI driven by the master-side SCLK generator and returns MISO.
- All SPI inputs are oversampled in the system clock domain; no logic is clocked by sclk.
- Presents a parallel RX word with a valid pulse, and a single-entry TX holding buffer with a ready/load handshake, to the slave-side register logic.

Parameters:
DATA_WIDTH, 8, bits per SPI word (>=2).
SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (>=2).

Ports:
clk  input  1  system clock; must be >= 4x sclk frequency.
rst  input  1  synchronous, active-high reset.
sclk  input  1  SPI serial clock from master, idle low.
cs_n  input  1  SPI chip select, active low.
mosi  input  1  master-out serial data.
miso  output  1  slave-out serial data, driven 0 when not selected (no tristate here).
tx_data  input  DATA_WIDTH  word to transmit next.
tx_load  input  1  write tx_data into TX buffer; honoured only when tx_ready=1.
tx_ready  output  1  TX buffer empty.
rx_data  output  DATA_WIDTH  last complete received word; holds until the next word completes.
rx_valid  output  1  one-cycle pulse, rx_data updated.
busy  output  1  frame in progress (state ACTIVE).
frame_err  output  1  see Optional Feature.

Behaviour:
- Reset (rst=1 at posedge clk): miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, frame_err=0. Internal state:
  - state=IDLE, bit_cnt=0, shifters=0, TX buffer empty.
  - Synchronizer chains forced to sclk=0, cs_n=1, mosi=0.
  - Reset mid-frame aborts the frame silently.
- Sync/edge detect:
  - sclk_s, cs_s, mosi_s are the outputs of SYNC_STAGES flops.
  - sclk_d is sclk_s delayed one clk.
  - rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d.
  - Pin edge to internal action latency is SYNC_STAGES+1 clk.
- bit_cnt width is clog2(DATA_WIDTH).
- IDLE: busy=0, miso=0. When cs_s=0:
  - go ACTIVE, bit_cnt=0, load TX shifter from the TX buffer (buffer -> empty).
  - If the buffer is empty, load all zeros instead.
  - miso = TX shifter MSB from the following cycle.
- ACTIVE: busy=1, miso = TX shifter MSB.
  - rise: rx shifter <= {rx shifter[DATA_WIDTH-2:0], mosi_s}; bit_cnt+1.
  - rise with bit_cnt=DATA_WIDTH-1:
    - next cycle rx_data = completed word and rx_valid=1 for exactly 1 clk.
    - bit_cnt wraps to 0; set word_done flag.
  - fall with word_done=1: reload TX shifter from the buffer (zeros if empty); clear word_done.
  - fall with word_done=0: TX shifter shifts left one bit, zero fill.
  - cs_s=1: return to IDLE next cycle. Partial RX bits are discarded with no rx_valid; bit_cnt=0.
- TX buffer handshake:
  - tx_load & tx_ready captures tx_data; tx_ready=0 next cycle.
  - tx_load while tx_ready=0 is ignored; buffer unchanged.
  - A consume (frame start or word reload) empties the buffer; tx_ready=1 next cycle.
  - tx_load in the same cycle as a consume of an empty buffer: shifter gets zeros, the loaded word stays in the buffer.
- Simultaneous events:
  - cs_s rising and sclk rise in the same cycle: cs wins, no shift, no rx_valid.
  - rx_valid and frame end in the same cycle: rx_valid still pulses.
- Multi-word frames (cs_n held low) are supported back-to-back with no gaps.

Optional Feature:
Macro SPI_SLAVE_FRAME_ERR_EN.
- Defined: frame_err is a one-clk pulse when cs_s rises in ACTIVE with bit_cnt!=0, i.e. the frame was truncated mid-word. It also pulses on a rise while cs_s=1 that is not preceded by a select.
- Not defined: frame_err is tied to 0 and no detection logic exists. All other behaviour is identical.

Test Plan:
- Reset: assert rst 3 clk mid-frame -> all outputs at reset values, busy=0, tx_ready=1; next full frame is received correctly.
- Single byte, DATA_WIDTH=8, clk 100 MHz, sclk 1.8 MHz: tx_load 0xA5, master sends 0x3C -> master samples 0xA5 on MISO; rx_data=0x3C with exactly one rx_valid pulse; tx_ready back to 1.
- Back-to-back: cs_n low for 16 sclk, MOSI 0x12,0x34, TX 0xC3 loaded, 0x5A loaded after the first consume -> rx_valid twice (0x12 then 0x34); MISO stream 0xC3,0x5A.
- TX underrun: no tx_load before the frame, master sends 0xFF -> MISO all 0; rx_data=0xFF.
- Aborted frame: cs_n rises after 5 sclk rises -> no rx_valid, rx_data unchanged, busy=0. frame_err pulses once only with SPI_SLAVE_FRAME_ERR_EN; otherwise it stays 0.
- Handshake: tx_load 0x11 then tx_load 0x22 while tx_ready=0 -> the transmitted word is 0x11; 0x22 is dropped.
